alu_sequencer: RTL and testbench

Multi-cycle issue controller that drives the combinational ALU from the request side and collects its outputs: it accepts a decoded RISC-V instruction with operands over a valid/ready handshake, selects ALU operands and `alu_op`, captures `alu_result`/`bcond` on the following edge, and, for branches, reuses the ALU to compute the target. It sits between decode/register-read and writeback/PC-update in the multi-cycle datapath.

---
 rtl/alu_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Multi-cycle issue controller for the combinational ALU.
//             Accepts a decoded RISC-V instruction over a valid/ready
//             handshake, drives ALU operands/operation, captures the ALU
//             result and branch condition, and reuses the ALU in a second
//             pass to form the branch target.
//  Ports    : clk, reset_n            clock, async active-low reset
//             req_valid/req_ready     request handshake
//             req_opcode/funct3/funct7, req_rs1/rs2/imm/pc  request fields
//             alu_in_1/alu_in_2/sign_extended_imm/alu_op     ALU drive
//             alu_result, bcond       ALU return path
//             rsp_valid/rsp_ready     response handshake
//             rsp_result/rsp_taken/rsp_next_pc/rsp_illegal   response fields
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [6:0]            req_opcode,
  input  logic [2:0]            req_funct3,
  input  logic [6:0]            req_funct7,
  input  logic [data_width-1:0] req_rs1,
  input  logic [data_width-1:0] req_rs2,
  input  logic [data_width-1:0] req_imm,
  input  logic [data_width-1:0] req_pc,
  // ALU drive and return
  output logic [data_width-1:0] alu_in_1,
  output logic [data_width-1:0] alu_in_2,
  output logic [data_width-1:0] sign_extended_imm,
  output logic [2:0]            alu_op,
  input  logic [data_width-1:0] alu_result,
  input  logic                  bcond,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_result,
  output logic                  rsp_taken,
  output logic [data_width-1:0] rsp_next_pc,
  output logic                  rsp_illegal
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_BR_TGT = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Opcodes
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU operation codes (shared with the ALU's funct3 decode)
  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

  localparam logic [data_width-1:0] PC_STEP = data_width'(4);

  logic [1:0]            state;
  logic [data_width-1:0] rs1_q;
  logic [data_width-1:0] rs2_q;
  logic [data_width-1:0] imm_q;
  logic [data_width-1:0] pc_q;
  logic [2:0]            op_q;
  logic                  use_imm_q;
  logic                  branch_q;
  logic                  taken_q;

  // Decoder outputs, evaluated on the raw request fields in IDLE
  logic                  dec_legal;
  logic [2:0]            dec_op;
  logic                  dec_use_imm;
  logic                  dec_branch;

  logic [data_width-1:0] req_pc_plus4;
  logic [data_width-1:0] pc_plus4;

  // Natural wrap of the adder gives modulo 2^data_width
  assign req_pc_plus4 = req_pc + PC_STEP;
  assign pc_plus4     = pc_q + PC_STEP;

  // req_ready is held low while reset is asserted so nothing is offered
  // to the requester until the sequencer is actually running.
  assign req_ready = (state == ST_IDLE) && reset_n;
  assign rsp_valid = (state == ST_RESP);

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = FUNCT3_ADD;
    dec_use_imm = 1'b0;
    dec_branch  = 1'b0;
    case (req_opcode)
      OPC_RTYPE: begin
        dec_op = req_funct3;
        case (req_funct3)
          3'b000:                      dec_legal = (req_funct7 == FUNCT7_ZERO) ||
                                                   (req_funct7 == FUNCT7_SUB);
          3'b001, 3'b100, 3'b101,
          3'b110, 3'b111:              dec_legal = (req_funct7 == FUNCT7_ZERO);
          default:                     dec_legal = 1'b0;
        endcase
      end
      OPC_ITYPE: begin
        dec_op      = req_funct3;
        dec_use_imm = 1'b1;
        case (req_funct3)
          // funct7 field only qualifies the shift-immediate forms; for the
          // others it is part of the immediate itself.
          3'b000, 3'b100, 3'b110, 3'b111: dec_legal = 1'b1;
          3'b001, 3'b101:                 dec_legal = (req_funct7 == FUNCT7_ZERO);
          default:                        dec_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_op      = FUNCT3_LW;
        dec_use_imm = 1'b1;
        dec_legal   = (req_funct3 == 3'b010);
      end
      OPC_STORE: begin
        dec_op      = FUNCT3_SW;
        dec_use_imm = 1'b1;
        dec_legal   = (req_funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        dec_op     = req_funct3;
        dec_branch = 1'b1;
        case (req_funct3)
          3'b000, 3'b001, 3'b100, 3'b101: dec_legal = 1'b1;
          default:                        dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer state and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      op_q        <= '0;
      use_imm_q   <= 1'b0;
      branch_q    <= 1'b0;
      taken_q     <= 1'b0;
      rsp_result  <= '0;
      rsp_next_pc <= '0;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            imm_q     <= req_imm;
            pc_q      <= req_pc;
            op_q      <= dec_op;
            use_imm_q <= dec_use_imm;
            branch_q  <= dec_branch;
            taken_q   <= 1'b0;
            if (dec_legal) begin
              state <= ST_EXEC;
            end else begin
              // Illegal instructions skip the ALU entirely
              rsp_result  <= '0;
              rsp_taken   <= 1'b0;
              rsp_illegal <= 1'b1;
              rsp_next_pc <= req_pc_plus4;
              state       <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (branch_q) begin
            taken_q <= bcond;
            state   <= ST_BR_TGT;
          end else begin
            rsp_result  <= alu_result;
            rsp_next_pc <= pc_plus4;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_BR_TGT: begin
          // Second ALU pass has computed pc + imm
          rsp_next_pc <= taken_q ? alu_result : pc_plus4;
          rsp_result  <= '0;
          rsp_taken   <= taken_q;
          rsp_illegal <= 1'b0;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // ALU drive: live only in EXEC and BR_TGT, quiet (zero) otherwise
  // --------------------------------------------------------------------------
  always_comb begin
    alu_in_1          = '0;
    alu_in_2          = '0;
    sign_extended_imm = '0;
    alu_op            = '0;
    case (state)
      ST_EXEC: begin
        alu_in_1          = rs1_q;
        alu_in_2          = use_imm_q ? imm_q : rs2_q;
        sign_extended_imm = imm_q;
        alu_op            = op_q;
      end
      ST_BR_TGT: begin
        alu_in_1          = pc_q;
        alu_in_2          = imm_q;
        sign_extended_imm = imm_q;
        alu_op            = FUNCT3_ADD;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Directed self-checking bench for alu_sequencer, with a small
//             behavioural ALU closing the loop on alu_in_*/alu_op.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_rs1, req_rs2, req_imm, req_pc;
  logic [31:0] alu_in_1, alu_in_2, sign_extended_imm;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        bcond;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_taken;
  logic [31:0] rsp_next_pc;
  logic        rsp_illegal;

  int checks = 0;
  int fails  = 0;

  // alu_op cannot tell ADD from SUB; the bench supplies that bit itself
  logic sub_mode = 1'b0;

  // Observations from the last run_req call
  int          obs_cycle;
  logic [31:0] obs_res, obs_npc, obs_in1, obs_in2, obs_sei, obs_tin1, obs_tin2;
  logic [2:0]  obs_op, obs_top;
  logic        obs_tk, obs_il, obs_idle;

  alu_sequencer #(.data_width(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_pc(req_pc),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .sign_extended_imm(sign_extended_imm),
    .alu_op(alu_op), .alu_result(alu_result), .bcond(bcond),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_taken(rsp_taken), .rsp_next_pc(rsp_next_pc), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_result = 32'h0;
    bcond      = 1'b0;
    case (alu_op)
      3'b000: begin alu_result = sub_mode ? alu_in_1 - alu_in_2 : alu_in_1 + alu_in_2;
                    bcond = (alu_in_1 == alu_in_2); end
      3'b001: begin alu_result = alu_in_1 << alu_in_2[4:0]; bcond = (alu_in_1 != alu_in_2); end
      3'b010: alu_result = alu_in_1 + alu_in_2;
      3'b100: begin alu_result = alu_in_1 ^ alu_in_2; bcond = ($signed(alu_in_1) < $signed(alu_in_2)); end
      3'b101: begin alu_result = alu_in_1 >> alu_in_2[4:0]; bcond = ($signed(alu_in_1) >= $signed(alu_in_2)); end
      3'b110: alu_result = alu_in_1 | alu_in_2;
      3'b111: alu_result = alu_in_1 & alu_in_2;
      default: ;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request with rsp_ready=1 and record what comes back.
  // obs_cycle counts the accept edge as cycle 0; the sample right after it
  // is cycle 1. 99 means no response within the budget.
  task automatic run_req(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = opc; req_funct3 = f3; req_funct7 = f7;
    req_rs1 = a; req_rs2 = b; req_imm = imm; req_pc = pc;
    @(posedge clk); #1;
    // Scramble the request bus after accept; it must have no effect
    req_valid = 1'b0; req_opcode = 7'h7F; req_funct3 = 3'h7; req_funct7 = 7'h7F;
    req_rs1 = 32'hDEADBEEF; req_rs2 = 32'hCAFEF00D; req_imm = 32'h12345678; req_pc = 32'h0BAD0BAD;
    obs_in1 = alu_in_1; obs_in2 = alu_in_2; obs_op = alu_op; obs_sei = sign_extended_imm;
    obs_tin1 = 32'h0; obs_tin2 = 32'h0; obs_top = 3'h0;
    n = 1;
    while (!rsp_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (n == 2 && !rsp_valid) begin
        obs_tin1 = alu_in_1; obs_tin2 = alu_in_2; obs_top = alu_op;
      end
    end
    obs_cycle = rsp_valid ? n : 99;
    obs_res = rsp_result; obs_npc = rsp_next_pc; obs_tk = rsp_taken; obs_il = rsp_illegal;
    @(posedge clk); #1;
    obs_idle = req_ready && !rsp_valid;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_opcode = 7'h0; req_funct3 = 3'h0; req_funct7 = 7'h0;
    req_rs1 = 32'h0; req_rs2 = 32'h0; req_imm = 32'h0; req_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if ({rsp_valid, rsp_taken, rsp_illegal} !== 3'b000) begin fails++;
      $display("FAIL reset_rsp_flags: got %b expected 000", {rsp_valid, rsp_taken, rsp_illegal}); end
    checks++; if ({rsp_result, rsp_next_pc} !== 64'h0) begin fails++;
      $display("FAIL reset_rsp_data: got %h expected 0", {rsp_result, rsp_next_pc}); end
    checks++; if ({alu_in_1, alu_in_2, sign_extended_imm, alu_op} !== 99'h0) begin fails++;
      $display("FAIL reset_alu_outputs: got %h expected 0", {alu_in_1, alu_in_2, sign_extended_imm, alu_op}); end
  endtask

  task automatic test_rtype_sub;
    sub_mode = 1'b1;
    run_req(7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'h0, 32'h100);
    sub_mode = 1'b0;
    checks++; if (obs_cycle !== 2) begin fails++; $display("FAIL sub_cycle: got %0d expected 2", obs_cycle); end
    checks++; if ({obs_in1, obs_in2, obs_op} !== {32'd10, 32'd3, 3'b000}) begin fails++;
      $display("FAIL sub_alu_drive: got %h %h %h expected a 3 0", obs_in1, obs_in2, obs_op); end
    checks++; if (obs_res !== 32'd7) begin fails++; $display("FAIL sub_result: got %h expected 7", obs_res); end
    checks++; if (obs_npc !== 32'h104) begin fails++; $display("FAIL sub_next_pc: got %h expected 104", obs_npc); end
    checks++; if ({obs_tk, obs_il, obs_idle} !== 3'b001) begin fails++;
      $display("FAIL sub_flags_idle: got %b expected 001", {obs_tk, obs_il, obs_idle}); end
  endtask

  task automatic test_itype_and_mem;
    run_req(7'b0010011, 3'b000, 7'h0, 32'hFFFFFFFF, 32'h55, 32'h1, 32'h200);
    checks++; if (obs_in2 !== 32'h1) begin fails++; $display("FAIL addi_in2: got %h expected 1", obs_in2); end
    checks++; if ({obs_res, obs_npc} !== {32'h0, 32'h204}) begin fails++;
      $display("FAIL addi_wrap: got %h %h expected 0 204", obs_res, obs_npc); end
    run_req(7'b0000011, 3'b010, 7'h0, 32'h100, 32'h77, 32'hFFFFFFFC, 32'h300);
    checks++; if ({obs_op, obs_sei} !== {3'b010, 32'hFFFFFFFC}) begin fails++;
      $display("FAIL lw_drive: got %h %h expected 2 fffffffc", obs_op, obs_sei); end
    checks++; if ({obs_cycle, obs_res} !== {32'd2, 32'hFC}) begin fails++;
      $display("FAIL lw_result: got cycle %0d res %h expected 2 fc", obs_cycle, obs_res); end
    run_req(7'b0100011, 3'b010, 7'h0, 32'h200, 32'h99, 32'h8, 32'h310);
    checks++; if ({obs_res, obs_il} !== {32'h208, 1'b0}) begin fails++;
      $display("FAIL sw_result: got %h il %b expected 208 0", obs_res, obs_il); end
    run_req(7'b0010011, 3'b101, 7'h0, 32'h80000000, 32'h0, 32'h4, 32'h320);
    checks++; if (obs_res !== 32'h08000000) begin fails++; $display("FAIL srli_result: got %h expected 08000000", obs_res); end
    run_req(7'b0110011, 3'b100, 7'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'hFFFFFFFC);
    checks++; if ({obs_res, obs_npc} !== {32'h00000FF0, 32'h0}) begin fails++;
      $display("FAIL xor_pc_wrap: got %h %h expected 00000ff0 0", obs_res, obs_npc); end
  endtask

  task automatic test_branch;
    run_req(7'b1100011, 3'b000, 7'h0, 32'd5, 32'd5, 32'h10, 32'h40);
    checks++; if (obs_cycle !== 3) begin fails++; $display("FAIL beq_cycle: got %0d expected 3", obs_cycle); end
    checks++; if ({obs_tin1, obs_tin2, obs_top} !== {32'h40, 32'h10, 3'b000}) begin fails++;
      $display("FAIL beq_target_drive: got %h %h %h expected 40 10 0", obs_tin1, obs_tin2, obs_top); end
    checks++; if ({obs_tk, obs_npc, obs_res} !== {1'b1, 32'h50, 32'h0}) begin fails++;
      $display("FAIL beq_taken: got tk %b npc %h res %h expected 1 50 0", obs_tk, obs_npc, obs_res); end
    run_req(7'b1100011, 3'b000, 7'h0, 32'd5, 32'd6, 32'h10, 32'h40);
    checks++; if ({obs_tk, obs_npc} !== {1'b0, 32'h44}) begin fails++;
      $display("FAIL beq_not_taken: got tk %b npc %h expected 0 44", obs_tk, obs_npc); end
    run_req(7'b1100011, 3'b001, 7'h0, 32'd1, 32'd2, 32'hFFFFFFF0, 32'h1000);
    checks++; if ({obs_tk, obs_npc} !== {1'b1, 32'h00000FF0}) begin fails++;
      $display("FAIL bne_back_taken: got tk %b npc %h expected 1 00000ff0", obs_tk, obs_npc); end
  endtask

  task automatic test_illegal;
    run_req(7'b0110011, 3'b010, 7'h0, 32'd1, 32'd2, 32'h0, 32'h500);
    checks++; if (obs_cycle !== 1) begin fails++; $display("FAIL slt_cycle: got %0d expected 1", obs_cycle); end
    checks++; if ({obs_il, obs_tk, obs_res, obs_npc} !== {1'b1, 1'b0, 32'h0, 32'h504}) begin fails++;
      $display("FAIL slt_rsp: got il %b tk %b res %h npc %h expected 1 0 0 504", obs_il, obs_tk, obs_res, obs_npc); end
    checks++; if ({obs_in1, obs_in2, obs_sei, obs_op} !== 99'h0) begin fails++;
      $display("FAIL slt_alu_quiet: got %h %h %h %h expected 0", obs_in1, obs_in2, obs_sei, obs_op); end
    run_req(7'b0110011, 3'b101, 7'b0100000, 32'd1, 32'd2, 32'h0, 32'h600);
    checks++; if ({obs_cycle, obs_il} !== {32'd1, 1'b1}) begin fails++;
      $display("FAIL sra_illegal: got cycle %0d il %b expected 1 1", obs_cycle, obs_il); end
    run_req(7'b0110111, 3'b000, 7'h0, 32'd1, 32'd2, 32'h0, 32'h700);
    checks++; if ({obs_il, obs_npc} !== {1'b1, 32'h704}) begin fails++;
      $display("FAIL lui_illegal: got il %b npc %h expected 1 704", obs_il, obs_npc); end
  endtask

  task automatic test_backpressure;
    int n;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 7'b0110011; req_funct3 = 3'b000; req_funct7 = 7'h0;
    req_rs1 = 32'd7; req_rs2 = 32'd8; req_imm = 32'h0; req_pc = 32'h800;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_rsp_valid: got %b expected 1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_rs1 = 32'd100 + i; req_pc = 32'h900;
      @(posedge clk); #1;
      checks++; if ({rsp_valid, req_ready, rsp_result, rsp_next_pc} !== {1'b1, 1'b0, 32'd15, 32'h804}) begin fails++;
        $display("FAIL bp_hold[%0d]: got v %b rdy %b res %h npc %h expected 1 0 f 804",
                 i, rsp_valid, req_ready, rsp_result, rsp_next_pc); end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin fails++;
      $display("FAIL bp_release_idle: got v %b rdy %b expected 0 1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin fails++;
      $display("FAIL bp_no_same_cycle_accept: got v %b rdy %b expected 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 7'b0110011; req_funct3 = 3'b110; req_funct7 = 7'h0;
    req_rs1 = 32'hA5A5A5A5; req_rs2 = 32'h0F0F0F0F; req_imm = 32'h0; req_pc = 32'hA00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (alu_in_1 !== 32'hA5A5A5A5) begin fails++; $display("FAIL mid_exec_in1: got %h expected a5a5a5a5", alu_in_1); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_taken, rsp_illegal, rsp_result, rsp_next_pc} !== 67'h0) begin fails++;
      $display("FAIL mid_reset_rsp: got %h expected 0", {rsp_valid, rsp_taken, rsp_illegal, rsp_result, rsp_next_pc}); end
    checks++; if ({alu_in_1, alu_in_2, sign_extended_imm, alu_op} !== 99'h0) begin fails++;
      $display("FAIL mid_reset_alu: got %h expected 0", {alu_in_1, alu_in_2, sign_extended_imm, alu_op}); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin fails++;
      $display("FAIL mid_reset_no_stale: got v %b rdy %b expected 0 1", rsp_valid, req_ready); end
    run_req(7'b0110011, 3'b000, 7'h0, 32'd1, 32'd2, 32'h0, 32'hB00);
    checks++; if ({obs_cycle, obs_res, obs_npc} !== {32'd2, 32'd3, 32'hB04}) begin fails++;
      $display("FAIL mid_reset_add: got cycle %0d res %h npc %h expected 2 3 b04", obs_cycle, obs_res, obs_npc); end
  endtask

  initial begin
    test_reset;
    test_rtype_sub;
    test_itype_and_mem;
    test_branch;
    test_illegal;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
